cpu_exit_monitor: RTL and testbench
===================================

// Module: cpu_exit_monitor
// PURPOSE
// - Snoops the two data-memory store lanes of the superscalar core (CPU_Top) and detects the program's exit store.
// - Counts cycles and retired stores, and raises a watchdog timeout.
// - Freezes the core on completion via cpu_halt.
// - Replaces polling of RAM[25] from the bench; provides the same end-of-program condition in RTL.
// PARAMETERS
// - EXIT_WORD_ADDR  25          data-RAM word index of the exit/status slot (byte address = 4*index)
// - PASS_VALUE      32'd25      exit value meaning "program passed"
// - TIMEOUT_CYCLES  100000      RUN cycles before timeout fires; 0 disables the watchdog
// - CNT_W           32          width of cycle_count and store_count
// PORTS
// - clk          in   1      system clock, rising edge
// - reset        in   1      synchronous, active-high
// - st0_we       in   1      lane-0 store valid (older in program order)
// - st0_addr     in   32     lane-0 store byte address
// - st0_wdata    in   32     lane-0 store data
// - st1_we       in   1      lane-1 store valid (younger in program order)
// - st1_addr     in   32     lane-1 store byte address
// - st1_wdata    in   32     lane-1 store data
// - cpu_halt     out  1      1 = core must stop fetching/committing (done | timeout)
// - done         out  1      exit store seen (sticky)
// - pass         out  1      done && exit_code == PASS_VALUE
// - timeout      out  1      watchdog expired before exit (sticky)
// - exit_code    out  32     data of the exit store
// - cycle_count  out  CNT_W  RUN cycles elapsed, saturating
// - store_count  out  CNT_W  stores observed in RUN, saturating
// BEHAVIOUR
// - Reset (sync, active-high): state=IDLE; all outputs 0.
// - States:
//   - IDLE -> RUN on the first clk edge with reset=0.
//   - RUN -> DONE on an exit store.
//   - RUN -> TIMEOUT when the watchdog expires.
//   - DONE and TIMEOUT hold until reset.
// - Exit store: stN_we=1 and stN_addr[31:2]==EXIT_WORD_ADDR. stN_addr[1:0] is ignored (word stores only).
// - RUN, each edge:
//   - cycle_count += 1.
//   - store_count += st0_we + st1_we (0..2).
//   - Both counters saturate at all-ones, with no wrap.
// - Dual hit in one cycle: lane 1 is younger, so exit_code = st1_wdata.
// - Latency: done, pass, exit_code and cpu_halt are registered and assert on the edge that samples the exit store (visible the next cycle). The store itself is counted.
// - Watchdog: when TIMEOUT_CYCLES!=0, RUN sees cycle_count==TIMEOUT_CYCLES-1 with no exit store -> TIMEOUT; timeout=1, cpu_halt=1.
// - Exit store and watchdog expiry on the same edge: exit wins (done=1, timeout=0).
// - In DONE/TIMEOUT: counters and exit_code freeze; further stores are ignored.
// - Reset mid-RUN or in DONE: the reset edge returns everything to IDLE values; reset has priority over all events.
// - Non-exit stores: counted only; no other effect.
// - pass is combinational from registered state: done && (exit_code==PASS_VALUE).
// STRUCTURE
// - Shared package cpu_mon_pkg:
//   - mon_state_t enum {IDLE, RUN, DONE, TIMEOUT}.
//   - Default constants EXIT_WORD_ADDR and PASS_VALUE (shared with the data-memory map).
// - One sub-module, store_lane_match, instantiated twice.
//   - Inputs: we, addr.
//   - Output: hit = we && addr[31:2]==EXIT_WORD_ADDR.
// - Top: state register, two saturating counters, exit_code register, priority logic.
// TESTING
// - Reset held 2 cycles, then released, no stores -> all outputs 0 during reset; IDLE->RUN; cycle_count=1 one edge after release.
// - Exit store: st0_we=1, st0_addr=32'd100, st0_wdata=25 in RUN -> next cycle done=1, pass=1, cpu_halt=1, exit_code=25; counters frozen afterwards.
// - Dual-lane hit: st0 stores 7, st1 stores 25, both to addr 100 -> exit_code=25, pass=1, store_count incremented by 2.
// - Watchdog: TIMEOUT_CYCLES=10, no exit -> timeout=1, cpu_halt=1 after 10 RUN cycles, cycle_count=10. With the exit store on cycle 10 instead -> done=1, timeout=0.
// - Non-exit traffic: stores to addr 0, 4 and 101 (byte 101 maps to word 25 -> exit) -> first two only increment store_count; addr 101 triggers done.
// - Reset asserted in DONE, and again mid-RUN -> all outputs 0 on the next edge; RUN resumes with counters restarting from 0.

Source files
------------

// File: rtl/cpu_mon_pkg.sv
// Shared types and data-memory map constants
// for the CPU exit monitor.
package cpu_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    TIMEOUT
  } mon_state_t;

  localparam int unsigned EXIT_WORD_ADDR = 25;
  localparam logic [31:0] PASS_VALUE     = 32'd25;

  // Number of stores retired this cycle (0..2).
  function automatic logic [1:0] lane_inc(
    input logic a,
    input logic b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/store_lane_match.sv
// Flags a store lane writing the exit/status word.
// Byte offset within the word is ignored.
module store_lane_match #(
  parameter int unsigned EXIT_WORD_ADDR = cpu_mon_pkg::EXIT_WORD_ADDR
) (
  input  logic        we,
  input  logic [31:0] addr,
  output logic        hit
);

  logic unused_lsb;

  // Word stores only: the low address bits do not select a slot.
  assign unused_lsb = ^addr[1:0];

  // Exit slot match on the word index.
  assign hit = we && (addr[31:2] == 30'(EXIT_WORD_ADDR));

endmodule

// File: rtl/cpu_exit_monitor.sv
// Snoops both store lanes for the exit store,
// counts cycles/stores and runs a watchdog.
module cpu_exit_monitor #(
  parameter int unsigned EXIT_WORD_ADDR = cpu_mon_pkg::EXIT_WORD_ADDR,
  parameter logic [31:0] PASS_VALUE     = cpu_mon_pkg::PASS_VALUE,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st0_we,
  input  logic [31:0]      st0_addr,
  input  logic [31:0]      st0_wdata,
  input  logic             st1_we,
  input  logic [31:0]      st1_addr,
  input  logic [31:0]      st1_wdata,
  output logic             cpu_halt,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [31:0]      exit_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] store_count
);

  import cpu_mon_pkg::*;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST =
    WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  mon_state_t state_q;
  mon_state_t state_d;

  logic [CNT_W-1:0] cyc_d;
  logic [CNT_W-1:0] stc_d;
  logic [31:0]      code_d;

  logic             hit0;
  logic             hit1;
  logic [1:0]       inc;
  logic [CNT_W:0]   cyc_sum;
  logic [CNT_W:0]   stc_sum;
  logic             wd_fire;

  store_lane_match #(
    .EXIT_WORD_ADDR(EXIT_WORD_ADDR)
  ) u_lane0 (
    .we   (st0_we),
    .addr (st0_addr),
    .hit  (hit0)
  );

  store_lane_match #(
    .EXIT_WORD_ADDR(EXIT_WORD_ADDR)
  ) u_lane1 (
    .we   (st1_we),
    .addr (st1_addr),
    .hit  (hit1)
  );

  // Carry bit of the widened sums flags saturation.
  assign inc     = lane_inc(st0_we, st1_we);
  assign cyc_sum = {1'b0, cycle_count}
                 + {{CNT_W{1'b0}}, 1'b1};
  assign stc_sum = {1'b0, store_count}
                 + {{(CNT_W-1){1'b0}}, inc};
  assign wd_fire = WD_EN && (cycle_count == WD_LAST);

  // Next state, counters and exit code; exit beats watchdog.
  always_comb begin
    state_d = state_q;
    cyc_d   = cycle_count;
    stc_d   = store_count;
    code_d  = exit_code;
    unique case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        cyc_d = cyc_sum[CNT_W] ? '1 : cyc_sum[CNT_W-1:0];
        stc_d = stc_sum[CNT_W] ? '1 : stc_sum[CNT_W-1:0];
        priority case (1'b1)
          hit1: code_d = st1_wdata;
          hit0: code_d = st0_wdata;
          default: ;
        endcase
        if (hit0 || hit1)
          state_d = DONE;
        else if (wd_fire)
          state_d = TIMEOUT;
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cycle_count <= '0;
      store_count <= '0;
      exit_code   <= '0;
    end else begin
      state_q     <= state_d;
      cycle_count <= cyc_d;
      store_count <= stc_d;
      exit_code   <= code_d;
    end
  end

  assign done     = (state_q == DONE);
  assign timeout  = (state_q == TIMEOUT);
  assign cpu_halt = done || timeout;
  assign pass     = done && (exit_code == PASS_VALUE);

endmodule

// File: tb/tb_cpu_exit_monitor.sv
// Scoreboard bench for cpu_exit_monitor
// with a 10-cycle watchdog.
module tb_cpu_exit_monitor;

  logic        clk;
  logic        reset;
  logic        st0_we;
  logic [31:0] st0_addr;
  logic [31:0] st0_wdata;
  logic        st1_we;
  logic [31:0] st1_addr;
  logic [31:0] st1_wdata;
  logic        cpu_halt;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] exit_code;
  logic [31:0] cycle_count;
  logic [31:0] store_count;

  typedef struct packed {
    logic        halt;
    logic        dn;
    logic        ps;
    logic        tmo;
    logic [31:0] code;
    logic [31:0] cyc;
    logic [31:0] stc;
  } exp_t;

  exp_t exp_q[$];

  int n_chk;
  int n_pass;

  int          m_state;
  logic [31:0] m_cyc;
  logic [31:0] m_stc;
  logic [31:0] m_code;

  cpu_exit_monitor #(
    .EXIT_WORD_ADDR(25),
    .PASS_VALUE    (32'd25),
    .TIMEOUT_CYCLES(10),
    .CNT_W         (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .st0_we     (st0_we),
    .st0_addr   (st0_addr),
    .st0_wdata  (st0_wdata),
    .st1_we     (st1_we),
    .st1_addr   (st1_addr),
    .st1_wdata  (st1_wdata),
    .cpu_halt   (cpu_halt),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .exit_code  (exit_code),
    .cycle_count(cycle_count),
    .store_count(store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  // Monitor: compare every registered update with the queued expectation.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {cpu_halt, done, pass, timeout,
               exit_code, cycle_count, store_count};
        n_chk++;
        if (got === e)
          n_pass++;
        else
          $display("FAIL sb t=%0t got h%0b d%0b p%0b t%0b c=%0d cy=%0d st=%0d exp h%0b d%0b p%0b t%0b c=%0d cy=%0d st=%0d",
                   $time, got.halt, got.dn, got.ps, got.tmo,
                   got.code, got.cyc, got.stc,
                   e.halt, e.dn, e.ps, e.tmo,
                   e.code, e.cyc, e.stc);
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
  endtask

  task automatic step(input logic        r,
                      input logic        w0,
                      input logic [31:0] a0,
                      input logic [31:0] d0,
                      input logic        w1,
                      input logic [31:0] a1,
                      input logic [31:0] d1);
    exp_t        e;
    logic        h0;
    logic        h1;
    logic [31:0] old_cyc;
    @(negedge clk);
    reset     = r;
    st0_we    = w0;
    st0_addr  = a0;
    st0_wdata = d0;
    st1_we    = w1;
    st1_addr  = a1;
    st1_wdata = d1;
    h0 = w0 && ((a0 >> 2) == 32'd25);
    h1 = w1 && ((a1 >> 2) == 32'd25);
    old_cyc = m_cyc;
    if (r) begin
      m_state = 0;
      m_cyc   = 0;
      m_stc   = 0;
      m_code  = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      m_cyc = m_cyc + 1;
      m_stc = m_stc + 32'(w0) + 32'(w1);
      if (h0 || h1) begin
        m_code  = h1 ? d1 : d0;
        m_state = 2;
      end else if (old_cyc == 32'd9) begin
        m_state = 3;
      end
    end
    e.dn   = (m_state == 2);
    e.tmo  = (m_state == 3);
    e.halt = e.dn || e.tmo;
    e.ps   = e.dn && (m_code == 32'd25);
    e.code = m_code;
    e.cyc  = m_cyc;
    e.stc  = m_stc;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_release();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] outs_or();
    return {28'd0, cpu_halt, done, pass, timeout}
         | exit_code | cycle_count | store_count;
  endfunction

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    m_state   = 0;
    m_cyc     = 0;
    m_stc     = 0;
    m_code    = 0;
    reset     = 1'b1;
    st0_we    = 1'b0;
    st0_addr  = '0;
    st0_wdata = '0;
    st1_we    = 1'b0;
    st1_addr  = '0;
    st1_wdata = '0;

    // Reset for two cycles, then release.
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_outs0", outs_or(), 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_outs1", outs_or(), 0);
    idle(1);
    chk("enter_run_cyc", cycle_count, 0);
    idle(1);
    chk("cyc_after_release", cycle_count, 1);

    // Single-lane exit store with the pass value.
    step(0, 1, 32'd100, 32'd25, 0, 0, 0);
    chk("exit_done", done, 1);
    chk("exit_pass", pass, 1);
    chk("exit_halt", cpu_halt, 1);
    chk("exit_code", exit_code, 25);
    step(0, 1, 32'd8, 32'd3, 1, 32'd100, 32'd7);
    chk("frozen_code", exit_code, 25);
    chk("frozen_cyc", cycle_count, 2);
    chk("frozen_stc", store_count, 1);

    // Reset in DONE, then dual-lane hit.
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_in_done", outs_or(), 0);
    idle(1);
    step(0, 1, 32'd8, 32'd1, 0, 0, 0);
    step(0, 1, 32'd100, 32'd7, 1, 32'd100, 32'd25);
    chk("dual_code", exit_code, 25);
    chk("dual_pass", pass, 1);
    chk("dual_stc", store_count, 3);

    // Watchdog expiry after 10 RUN cycles.
    rst_release();
    idle(9);
    chk("wd_not_yet", timeout, 0);
    idle(1);
    chk("wd_timeout", timeout, 1);
    chk("wd_halt", cpu_halt, 1);
    chk("wd_cyc", cycle_count, 10);
    chk("wd_done", done, 0);
    step(0, 1, 32'd100, 32'd25, 0, 0, 0);
    chk("wd_ignore_store", store_count, 0);

    // Exit store on the watchdog edge wins; non-pass value.
    rst_release();
    idle(9);
    step(0, 1, 32'd100, 32'd3, 0, 0, 0);
    chk("race_done", done, 1);
    chk("race_tmo", timeout, 0);
    chk("race_pass", pass, 0);
    chk("race_cyc", cycle_count, 10);

    // Non-exit traffic, then byte address 101.
    rst_release();
    step(0, 1, 32'd0, 32'd25, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'd4, 32'd25);
    chk("nonexit_done", done, 0);
    chk("nonexit_stc", store_count, 2);
    step(0, 1, 32'd101, 32'd25, 0, 0, 0);
    chk("addr101_done", done, 1);
    chk("addr101_stc", store_count, 3);

    // Reset mid-RUN and restart.
    rst_release();
    idle(3);
    chk("mid_cyc", cycle_count, 3);
    step(1, 1, 32'd100, 32'd25, 0, 0, 0);
    chk("rst_mid_run", outs_or(), 0);
    idle(2);
    chk("restart_cyc", cycle_count, 1);

    idle(2);
    n_chk++;
    if (exp_q.size() == 0)
      n_pass++;
    else
      $display("FAIL sb_drain got=%0d exp=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
